exec_mul_sequencer: RTL

- Multi-cycle shift-add multiply sequencer that time-shares the execute-stage ALU between the pipeline and a MUL instruction.
- In IDLE it passes the pipeline's ALU operands and control straight through.
- On a MUL start it takes ownership of the ALU, iterates add steps, and stalls the pipeline.
- It then presents the lower N bits of the product for one cycle with done.

---
 rtl/exec_mul_sequencer.sv | 128 ++++++++++++
 1 files changed

// File: rtl/exec_mul_sequencer.sv
// rtl/exec_mul_sequencer.sv - shift-add MUL sequencer that borrows the execute-stage ALU
// Passes pipeline ALU traffic through when idle; owns the ALU and stalls while multiplying.
module exec_mul_sequencer #(
  parameter int          N        = 64,
  parameter int          CNT_W    = 7,
  parameter int          EARLY    = 0,
  parameter logic [3:0]  ADD_CTRL = 4'b0010
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [N-1:0]   opA,
  input  logic [N-1:0]   opB,
  input  logic [3:0]     pipe_AluControl,
  input  logic [N-1:0]   pipe_in1,
  input  logic [N-1:0]   pipe_in2,
  input  logic [N-1:0]   alu_result,
  output logic [3:0]     alu_control,
  output logic [N-1:0]   alu_in1,
  output logic [N-1:0]   alu_in2,
  output logic           stall,
  output logic           busy,
  output logic           done,
  output logic [N-1:0]   product
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [N-1:0]       mcand_q, mcand_d;
  logic [N-1:0]       mplier_q, mplier_d;
  logic [N-1:0]       acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N-1:0]       product_q, product_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               last_step;

  // Early exit looks at the multiplier after this step's shift.
  assign last_step = (cnt_q == CNT_W'(N - 1)) ||
                     ((EARLY != 0) && ((mplier_q >> 1) == '0));

  always_comb begin
    alu_control = pipe_AluControl;
    alu_in1     = pipe_in1;
    alu_in2     = pipe_in2;
    if (state_q == S_RUN) begin
      alu_control = ADD_CTRL;
      alu_in1     = acc_q;
      alu_in2     = mplier_q[0] ? mcand_q : '0;
    end
  end

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mcand_d  = opA;
          mplier_d = opB;
          acc_d    = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        acc_d    = alu_result;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        busy_d   = 1'b1;
        if (last_step) begin
          product_d = alu_result;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // The MUL in IDLE must freeze the pipeline in the very cycle it is seen.
  assign stall   = ~reset & (busy_q | ((state_q == S_IDLE) & start));
  assign busy    = ~reset & busy_q;
  assign done    = ~reset & done_q;
  assign product = product_q;

endmodule
